// File: rtl/branch_resolve_unit_pkg.sv
// Shared definitions for the EX-stage branch resolution slice:
// RISC-V B-type condition codes and the resolve/flush FSM state.
package branch_resolve_unit_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_t;

endpackage

// File: rtl/branch_resolve_unit_cmp.sv
// Combinational RISC-V branch condition evaluator (funct3, rs1, rs2 -> taken).
// Reserved codes 010/011 resolve as not-taken.
module branch_cmp
    import branch_resolve_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            taken
);

    always_comb begin
        taken = 1'b0;
        case (funct3)
            F3_BEQ:  taken = (rs1 == rs2);
            F3_BNE:  taken = (rs1 != rs2);
            F3_BLT:  taken = ($signed(rs1) <  $signed(rs2));
            F3_BGE:  taken = ($signed(rs1) >= $signed(rs2));
            F3_BLTU: taken = (rs1 <  rs2);
            F3_BGEU: taken = (rs1 >= rs2);
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolution: one-cycle predictor update strobe, PC redirect and
// multi-cycle flush on mispredict, saturating branch/mispredict statistics.
module branch_resolve_unit
    import branch_resolve_unit_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ex_valid,
    input  logic             ex_is_branch,
    input  logic [2:0]       ex_funct3,
    input  logic [XLEN-1:0]  ex_rs1,
    input  logic [XLEN-1:0]  ex_rs2,
    input  logic [XLEN-1:0]  ex_pc,
    input  logic [XLEN-1:0]  ex_imm,
    input  logic             ex_pred_taken,
    output logic             branchex,
    output logic             outcome,
    output logic             redirect_valid,
    output logic [XLEN-1:0]  redirect_pc,
    output logic             flush,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] mispredict_count
);

    localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES - 1);

    state_t            state, state_nxt;
    logic [3:0]        fcnt, fcnt_nxt;
    logic              taken;
    logic              accept;
    logic              mispredict;
    logic [XLEN-1:0]   target;

    branch_cmp #(.XLEN(XLEN)) u_cmp (
        .funct3 (ex_funct3),
        .rs1    (ex_rs1),
        .rs2    (ex_rs2),
        .taken  (taken)
    );

    // EX inputs during a flush are wrong-path and never accepted.
    assign accept     = (state == IDLE) && ex_valid && ex_is_branch;
    assign mispredict = taken ^ ex_pred_taken;
    assign target     = taken ? (ex_pc + ex_imm) : (ex_pc + XLEN'(4));
    assign flush      = (state == FLUSH);

    always_comb begin
        state_nxt = state;
        fcnt_nxt  = fcnt;
        case (state)
            IDLE: begin
                if (accept && mispredict) begin
                    state_nxt = FLUSH;
                    fcnt_nxt  = FLUSH_INIT;
                end
            end
            FLUSH: begin
                if (fcnt == 4'd0) state_nxt = IDLE;
                else              fcnt_nxt  = fcnt - 4'd1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            fcnt  <= 4'd0;
        end else begin
            state <= state_nxt;
            fcnt  <= fcnt_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            branchex         <= 1'b0;
            outcome          <= 1'b0;
            redirect_valid   <= 1'b0;
            redirect_pc      <= '0;
            branch_count     <= '0;
            mispredict_count <= '0;
        end else begin
            branchex       <= accept;
            outcome        <= accept && taken;
            redirect_valid <= accept && mispredict;
            if (accept && mispredict)
                redirect_pc <= target;
            if (accept && (branch_count != {CNT_W{1'b1}}))
                branch_count <= branch_count + 1'b1;
            if (accept && mispredict && (mispredict_count != {CNT_W{1'b1}}))
                mispredict_count <= mispredict_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: directed literal cases plus randomized traffic
// against a cycle-level behavioural model; second instance with CNT_W=2 for saturation.
module tb_branch_resolve_unit;

    localparam int FC = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, ex_is_branch, ex_pred_taken;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_rs1, ex_rs2, ex_pc, ex_imm;

    logic        branchex, outcome, redirect_valid, flush;
    logic [31:0] redirect_pc;
    logic [15:0] branch_count, mispredict_count;

    logic        s_branchex, s_outcome, s_redirect_valid, s_flush;
    logic [31:0] s_redirect_pc;
    logic [1:0]  s_branch_count, s_mispredict_count;

    always #5 clk = ~clk;

    branch_resolve_unit #(.XLEN(32), .FLUSH_CYCLES(FC), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_is_branch(ex_is_branch),
        .ex_funct3(ex_funct3), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_pc(ex_pc),
        .ex_imm(ex_imm), .ex_pred_taken(ex_pred_taken),
        .branchex(branchex), .outcome(outcome), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .flush(flush),
        .branch_count(branch_count), .mispredict_count(mispredict_count)
    );

    branch_resolve_unit #(.XLEN(32), .FLUSH_CYCLES(FC), .CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_is_branch(ex_is_branch),
        .ex_funct3(ex_funct3), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_pc(ex_pc),
        .ex_imm(ex_imm), .ex_pred_taken(ex_pred_taken),
        .branchex(s_branchex), .outcome(s_outcome), .redirect_valid(s_redirect_valid),
        .redirect_pc(s_redirect_pc), .flush(s_flush),
        .branch_count(s_branch_count), .mispredict_count(s_mispredict_count)
    );

    int n_vec = 0;
    int n_err = 0;

    // Model: expected outputs for the coming cycle, remaining flush cycles, raw totals.
    logic        e_bx, e_oc, e_rv;
    logic [31:0] e_pc;
    int          flush_left;
    int          br_total, mp_total;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic ref_taken(logic [2:0] f3, logic [31:0] a, logic [31:0] b);
        case (f3)
            3'b000:  return a == b;
            3'b001:  return a != b;
            3'b100:  return $signed(a) <  $signed(b);
            3'b101:  return $signed(a) >= $signed(b);
            3'b110:  return a <  b;
            3'b111:  return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    function automatic int sat(int v, int mx);
        return (v > mx) ? mx : v;
    endfunction

    function automatic void model_reset();
        e_bx = 0; e_oc = 0; e_rv = 0; e_pc = '0;
        flush_left = 0; br_total = 0; mp_total = 0;
    endfunction

    // Apply inputs for the current cycle and predict the next cycle's outputs.
    task automatic drive(input logic v, input logic b, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] bb,
                         input logic [31:0] pc, input logic [31:0] imm, input logic p);
        logic t;
        ex_valid = v; ex_is_branch = b; ex_funct3 = f3;
        ex_rs1 = a; ex_rs2 = bb; ex_pc = pc; ex_imm = imm; ex_pred_taken = p;
        e_bx = 0; e_oc = 0; e_rv = 0;
        if (flush_left > 0) begin
            flush_left--;
        end else if (v && b) begin
            t = ref_taken(f3, a, bb);
            e_bx = 1; e_oc = t; br_total++;
            if (t != p) begin
                e_rv = 1; mp_total++; flush_left = FC;
                e_pc = t ? pc + imm : pc + 32'd4;
            end
        end
    endtask

    task automatic idle();
        drive(0, 0, 3'b000, 0, 0, 0, 0, 0);
    endtask

    task automatic cycle_check();
        @(posedge clk); #1;
        chk("branchex", {31'b0, branchex}, {31'b0, e_bx});
        chk("outcome", {31'b0, outcome}, {31'b0, e_oc});
        chk("redirect_valid", {31'b0, redirect_valid}, {31'b0, e_rv});
        chk("redirect_pc", redirect_pc, e_pc);
        chk("flush", {31'b0, flush}, {31'b0, logic'(flush_left > 0)});
        chk("branch_count", {16'b0, branch_count}, 32'(sat(br_total, 65535)));
        chk("mispredict_count", {16'b0, mispredict_count}, 32'(sat(mp_total, 65535)));
        chk("sat_branch_count", {30'b0, s_branch_count}, 32'(sat(br_total, 3)));
        chk("sat_mispredict_count", {30'b0, s_mispredict_count}, 32'(sat(mp_total, 3)));
    endtask

    initial begin
        logic [31:0] a, b;
        rst = 1'b1;
        model_reset();
        idle();
        #2;
        chk("rst_branchex", {31'b0, branchex}, 32'd0);
        chk("rst_flush", {31'b0, flush}, 32'd0);
        chk("rst_redirect_pc", redirect_pc, 32'd0);
        chk("rst_branch_count", {16'b0, branch_count}, 32'd0);
        #10 rst = 1'b0;
        idle();
        cycle_check();

        // BEQ taken, predicted not-taken
        drive(1, 1, 3'b000, 5, 5, 32'h100, 32'h20, 0);
        cycle_check();
        chk("beq_outcome", {31'b0, outcome}, 32'd1);
        chk("beq_redirect", {31'b0, redirect_valid}, 32'd1);
        chk("beq_pc", redirect_pc, 32'h120);
        chk("beq_mcount", {16'b0, mispredict_count}, 32'd1);
        chk("beq_flush1", {31'b0, flush}, 32'd1);
        idle(); cycle_check();
        chk("beq_flush2", {31'b0, flush}, 32'd1);
        idle(); cycle_check();
        chk("beq_flush_end", {31'b0, flush}, 32'd0);

        // Back-to-back correct predictions, then BLTU mispredict
        drive(1, 1, 3'b001, 7, 7, 32'h140, 32'h10, 0);
        cycle_check();
        chk("bne_branchex", {31'b0, branchex}, 32'd1);
        chk("bne_outcome", {31'b0, outcome}, 32'd0);
        chk("bne_noflush", {31'b0, flush}, 32'd0);
        drive(1, 1, 3'b100, 32'hFFFFFFFF, 1, 32'h144, 32'h10, 1);
        cycle_check();
        chk("blt_branchex", {31'b0, branchex}, 32'd1);
        chk("blt_outcome", {31'b0, outcome}, 32'd1);
        chk("blt_noredirect", {31'b0, redirect_valid}, 32'd0);
        drive(1, 1, 3'b110, 32'hFFFFFFFF, 1, 32'h200, 32'h40, 1);
        cycle_check();
        chk("bltu_outcome", {31'b0, outcome}, 32'd0);
        chk("bltu_pc", redirect_pc, 32'h204);
        // Wrong-path branches during both flush cycles are ignored
        drive(1, 1, 3'b000, 1, 2, 32'h300, 32'h8, 1);
        cycle_check();
        chk("wp1_branchex", {31'b0, branchex}, 32'd0);
        drive(1, 1, 3'b000, 1, 2, 32'h304, 32'h8, 1);
        cycle_check();
        chk("wp2_branchex", {31'b0, branchex}, 32'd0);
        chk("wp_bcount", {16'b0, branch_count}, 32'd4);

        // Fall-through wraps modulo 2^32
        drive(1, 1, 3'b000, 1, 2, 32'hFFFFFFFC, 32'h8, 1);
        cycle_check();
        chk("wrap_pc", redirect_pc, 32'h0);
        chk("wrap_redirect", {31'b0, redirect_valid}, 32'd1);
        idle(); cycle_check();
        idle(); cycle_check();

        // Reset asserted in the first flush cycle
        drive(1, 1, 3'b101, 3, 3, 32'h400, 32'h80, 0);
        cycle_check();
        chk("prerst_flush", {31'b0, flush}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("midrst_flush", {31'b0, flush}, 32'd0);
        chk("midrst_bcount", {16'b0, branch_count}, 32'd0);
        chk("midrst_mcount", {16'b0, mispredict_count}, 32'd0);
        model_reset();
        idle();
        cycle_check();
        rst = 1'b0;
        idle();
        for (int i = 0; i < 3; i++) begin
            cycle_check();
            chk("postrst_redirect", {31'b0, redirect_valid}, 32'd0);
            idle();
        end

        // Five mispredicts saturate the 2-bit counters
        for (int i = 0; i < 5; i++) begin
            drive(1, 1, 3'b111, 9, 2, 32'h500 + 32'(i * 4), 32'h10, 0);
            cycle_check();
            idle(); cycle_check();
            idle(); cycle_check();
        end
        chk("sat_mcount", {30'b0, s_mispredict_count}, 32'd3);
        chk("wide_mcount", {16'b0, mispredict_count}, 32'd5);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            a = $urandom;
            b = ($urandom_range(3) == 0) ? a : $urandom;
            if ($urandom_range(3) == 0) begin
                a = 32'($urandom_range(7)) - 32'd3;
                b = 32'($urandom_range(7)) - 32'd3;
            end
            drive(logic'($urandom_range(9) < 8), logic'($urandom_range(9) < 7),
                  3'($urandom_range(7)), a, b, $urandom, $urandom, logic'($urandom_range(1)));
            cycle_check();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
